// File: rtl/vote_report_pkg.sv
// rtl/vote_report_pkg.sv - shared constants, state type and checksum helper for the vote report transmitter
package vote_report_pkg;

    localparam logic [7:0] HEADER    = 8'hA5;
    localparam int         FRAME_LEN = 6;

    localparam logic [3:0] CAND1_ID = 4'h1;
    localparam logic [3:0] CAND2_ID = 4'h2;
    localparam logic [3:0] CAND3_ID = 4'h3;
    localparam logic [3:0] CAND4_ID = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    function automatic logic [7:0] frame_checksum(input logic [7:0] b1, input logic [7:0] b2,
                                                  input logic [7:0] b3, input logic [7:0] b4);
        return HEADER ^ b1 ^ b2 ^ b3 ^ b4;
    endfunction

endpackage

// File: rtl/vote_report_tx_if.sv
// rtl/vote_report_tx_if.sv - control, tally and serial-line signals of the vote report transmitter
interface vote_report_tx_if;
    logic       mode;
    logic       report_req;
    logic [3:0] cand1_votes;
    logic [3:0] cand2_votes;
    logic [3:0] cand3_votes;
    logic [3:0] cand4_votes;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output mode, report_req, cand1_votes, cand2_votes, cand3_votes, cand4_votes,
        input  tx, busy, done
    );

    modport slave (
        input  mode, report_req, cand1_votes, cand2_votes, cand3_votes, cand4_votes,
        output tx, busy, done
    );
endinterface

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - single-byte 8N1 serializer that can chain bytes without idle bits
module uart_byte_tx
    import vote_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tdata,
    input  logic       tvalid,
    output logic       tready,
    output logic       byte_end,
    output logic       tx
);

    localparam int              CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    data, data_n;
    logic          tx_n;
    logic          bit_end;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            data    <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            data    <= data_n;
            tx      <= tx_n;
        end
    end

    // tx is computed one cycle ahead so the line is always a plain register
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        data_n    = data;
        tx_n      = tx;
        tready    = 1'b0;
        bit_end   = (cnt == CNT_MAX);
        byte_end  = (state == ST_STOP) && bit_end;
        case (state)
            ST_IDLE: begin
                tready = 1'b1;
                cnt_n  = '0;
                tx_n   = 1'b1;
                if (tvalid) begin
                    state_n = ST_START;
                    data_n  = tdata;
                    tx_n    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = ST_DATA;
                    tx_n      = data[0];
                    data_n    = data >> 1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = data[0];
                        data_n    = data >> 1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_n  = '0;
                    tready = 1'b1;
                    if (tvalid) begin
                        state_n = ST_START;
                        data_n  = tdata;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/vote_report_tx.sv
// rtl/vote_report_tx.sv - snapshots four vote tallies and sends them as a 6-byte checksummed UART frame
module vote_report_tx
    import vote_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic            clock,
    input  logic            reset,
    vote_report_tx_if.slave bus
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    logic [3:0] snap1, snap2, snap3, snap4;
    logic [2:0] byte_idx;
    logic       busy_q, done_q;
    logic       accept;
    logic       ser_tvalid, ser_tready, byte_end;
    logic [7:0] ser_tdata;
    logic [7:0] b1, b2, b3, b4;

    assign b1 = {CAND1_ID, snap1};
    assign b2 = {CAND2_ID, snap2};
    assign b3 = {CAND3_ID, snap3};
    assign b4 = {CAND4_ID, snap4};

    assign accept = bus.report_req & bus.mode & ~busy_q;

    // The header needs no snapshot, so it is offered on the acceptance cycle itself;
    // afterwards the byte after byte_idx is offered for the end of each stop bit.
    always_comb begin
        ser_tdata  = HEADER;
        ser_tvalid = busy_q ? (byte_idx != LAST_IDX) : accept;
        if (busy_q) begin
            case (byte_idx)
                3'd0:    ser_tdata = b2 ^ b2 ^ b1;
                3'd1:    ser_tdata = b2;
                3'd2:    ser_tdata = b3;
                3'd3:    ser_tdata = b4;
                default: ser_tdata = frame_checksum(b1, b2, b3, b4);
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap1    <= '0;
            snap2    <= '0;
            snap3    <= '0;
            snap4    <= '0;
            byte_idx <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                snap1    <= bus.cand1_votes;
                snap2    <= bus.cand2_votes;
                snap3    <= bus.cand3_votes;
                snap4    <= bus.cand4_votes;
                byte_idx <= '0;
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                if (byte_end && (byte_idx == LAST_IDX)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else if (ser_tvalid && ser_tready) begin
                    byte_idx <= byte_idx + 3'd1;
                end
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clock   (clock),
        .reset   (reset),
        .tdata   (ser_tdata),
        .tvalid  (ser_tvalid),
        .tready  (ser_tready),
        .byte_end(byte_end),
        .tx      (bus.tx)
    );

endmodule

// File: tb/tb_vote_report_tx.sv
// tb/tb_vote_report_tx.sv - randomized and directed self-checking bench for vote_report_tx
module tb_vote_report_tx;

    localparam int CPB = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    vote_report_tx_if bus();

    vote_report_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    bit         exp_lv[$];
    logic       exp_done = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] frame_of(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] c, input logic [3:0] d);
        logic [7:0] x;
        x = 8'hA5 ^ {4'h1, a} ^ {4'h2, b} ^ {4'h3, c} ^ {4'h4, d};
        return {x, 4'h4, d, 4'h3, c, 4'h2, b, 4'h1, a, 8'hA5};
    endfunction

    // Reference: a frame is the list of line levels it must produce, one entry per cycle
    bit          m_busy;
    bit          m_lvl;
    logic [47:0] m_fr;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            exp_lv.delete();
            exp_done = 1'b0;
        end else begin
            m_busy = (exp_lv.size() != 0);
            if (m_busy) void'(exp_lv.pop_front());
            exp_done = m_busy && (exp_lv.size() == 0);
            if (!m_busy && bus.report_req && bus.mode) begin
                m_fr = frame_of(bus.cand1_votes, bus.cand2_votes, bus.cand3_votes, bus.cand4_votes);
                for (int i = 0; i < 6; i++) begin
                    exp_q.push_back(m_fr[8*i +: 8]);
                    for (int b = 0; b < 10; b++) begin
                        m_lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_fr[8*i + b - 1];
                        repeat (CPB) exp_lv.push_back(m_lvl);
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        chk_bit("tx",   bus.tx,   (exp_lv.size() != 0) ? exp_lv[0] : 1'b1);
        chk_bit("busy", bus.busy, exp_lv.size() != 0);
        chk_bit("done", bus.done, exp_done);
        if (bus.done) done_cnt++;
    end

    // Independent UART receiver sampling mid-bit
    bit         rx_on = 1'b0;
    int         rx_p = 0;
    logic [7:0] rx_sh = '0;
    always @(negedge clock) begin
        if (!reset) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (bus.tx == 1'b0) begin
                rx_on = 1'b1;
                rx_p  = 0;
            end
        end else begin
            rx_p++;
            if ((rx_p % CPB == CPB / 2) && (rx_p / CPB >= 1) && (rx_p / CPB <= 8))
                rx_sh[rx_p / CPB - 1] = bus.tx;
            if (rx_p == 9 * CPB + CPB / 2) begin
                chk_bit("stop_bit", bus.tx, 1'b1);
                rx_q.push_back(rx_sh);
            end
            if (rx_p == 10 * CPB - 1) rx_on = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_req();
        bus.report_req = 1'b1;
        @(negedge clock);
        bus.report_req = 1'b0;
    endtask

    task automatic set_tallies(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d);
        bus.cand1_votes = a;
        bus.cand2_votes = b;
        bus.cand3_votes = c;
        bus.cand4_votes = d;
    endtask

    task automatic wait_done(input string nm, input int limit);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!bus.done && k < limit);
        chk_bit(nm, bus.done, 1'b1);
    endtask

    task automatic check_frame(input string nm, input logic [47:0] lit);
        chk_int({nm, "_rxlen"}, rx_q.size(), 6);
        chk_int({nm, "_mdllen"}, exp_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (rx_q.size() != 0) chk_int({nm, "_rx"}, int'(rx_q.pop_front()), int'(lit[8*i +: 8]));
            if (exp_q.size() != 0) chk_int({nm, "_mdl"}, int'(exp_q.pop_front()), int'(lit[8*i +: 8]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic drain_compare(input string nm);
        chk_int({nm, "_count"}, rx_q.size(), exp_q.size());
        while (rx_q.size() != 0 && exp_q.size() != 0)
            chk_int({nm, "_byte"}, int'(rx_q.pop_front()), int'(exp_q.pop_front()));
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n, d0, cnt, k;
        bus.mode       = 1'b0;
        bus.report_req = 1'b0;
        set_tallies(4'd0, 4'd0, 4'd0, 4'd0);
        cyc(3);
        chk_bit("reset_tx",   bus.tx,   1'b1);
        chk_bit("reset_busy", bus.busy, 1'b0);
        chk_bit("reset_done", bus.done, 1'b0);
        reset = 1'b1;
        cyc(2);

        // Frame 3,0,9,15 and done latency from the start bit
        bus.mode = 1'b1;
        set_tallies(4'd3, 4'd0, 4'd9, 4'd15);
        pulse_req();
        chk_bit("start_bit_after_accept", bus.tx, 1'b0);
        chk_bit("busy_rises_with_start", bus.busy, 1'b1);
        n = 0;
        while (!bus.done && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk_int("done_latency", n, 240);
        cyc(2);
        check_frame("frame_3_0_9_15", 48'hE0_4F_39_20_13_A5);

        // All-zero tallies
        set_tallies(4'd0, 4'd0, 4'd0, 4'd0);
        pulse_req();
        wait_done("zero_done", 400);
        cyc(2);
        check_frame("frame_zero", 48'hE5_40_30_20_10_A5);

        // Request with mode low is dropped
        d0 = done_cnt;
        bus.mode = 1'b0;
        pulse_req();
        cyc(20);
        chk_bit("mode0_busy", bus.busy, 1'b0);
        chk_bit("mode0_tx", bus.tx, 1'b1);
        chk_int("mode0_done", done_cnt, d0);
        chk_int("mode0_rx", rx_q.size(), 0);

        // Requests while busy are ignored
        bus.mode = 1'b1;
        set_tallies(4'd5, 4'd6, 4'd7, 4'd8);
        d0 = done_cnt;
        pulse_req();
        cyc(30);
        set_tallies(4'd1, 4'd1, 4'd1, 4'd1);
        pulse_req();
        cyc(100);
        pulse_req();
        wait_done("busy_req_done", 400);
        cyc(5);
        chk_int("busy_req_single_done", done_cnt, d0 + 1);
        check_frame("frame_busy_req", 48'hE9_48_37_26_15_A5);

        // Tally change mid-frame does not leak into the frame
        set_tallies(4'd3, 4'd0, 4'd0, 4'd0);
        pulse_req();
        cyc(20);
        bus.cand1_votes = 4'd4;
        wait_done("snapshot_done", 400);
        cyc(2);
        check_frame("frame_snapshot", 48'hE6_40_30_20_13_A5);

        // Reset during byte 2 aborts the frame without a done pulse
        set_tallies(4'd1, 4'd2, 4'd3, 4'd4);
        pulse_req();
        cyc(90);
        d0 = done_cnt;
        #1 reset = 1'b0;
        #1;
        chk_bit("abort_tx", bus.tx, 1'b1);
        chk_bit("abort_busy", bus.busy, 1'b0);
        chk_bit("abort_done", bus.done, 1'b0);
        cyc(3);
        reset = 1'b1;
        cyc(300);
        chk_int("abort_no_done", done_cnt, d0);
        rx_q.delete();
        exp_q.delete();
        pulse_req();
        wait_done("after_abort_done", 400);
        cyc(2);
        check_frame("frame_after_abort", 48'hE1_44_33_22_11_A5);

        // Request held high: back-to-back frames
        set_tallies(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        bus.report_req = 1'b1;
        cnt = 0;
        k = 0;
        while (cnt < 3 && k < 1000) begin
            @(negedge clock);
            k++;
            if (bus.done) begin
                cnt++;
                if (cnt == 3) begin
                    bus.report_req = 1'b0;
                end else begin
                    @(negedge clock);
                    k++;
                    chk_bit("b2b_start", bus.tx, 1'b0);
                end
            end
        end
        chk_int("b2b_frames", cnt, 3);
        cyc(3);
        drain_compare("b2b");

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bus.mode       = ($urandom_range(0, 3) != 0);
            bus.report_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0)
                set_tallies(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            @(negedge clock);
        end
        bus.report_req = 1'b0;
        k = 0;
        while (bus.busy && k < 400) begin
            @(negedge clock);
            k++;
        end
        chk_bit("random_idle", bus.busy, 1'b0);
        cyc(3);
        drain_compare("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vote_report_tx.md
VOTE_REPORT_TX -- requirements
Module: vote_report_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (legal >= 2).
REQ-002 SHALL have port clock  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mode  input  1  1 = result mode; reports permitted only when high.
REQ-005 SHALL have port report_req  input  1  request to transmit one report frame.
REQ-006 SHALL have ports cand1_votes..cand4_votes  input  4 each  current per-candidate tallies.
REQ-007 SHALL have port tx  output  1  UART serial line, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a frame completes.

Function
REQ-010 SHALL accept report_req only on a cycle where it is high, mode=1 and busy=0; all other requests are dropped, not queued.
REQ-011 SHALL snapshot all four tallies on the acceptance cycle; later tally changes do not affect the frame in flight.
REQ-012 SHALL send a 6-byte frame: 0xA5, {4'h1,cand1}, {4'h2,cand2}, {4'h3,cand3}, {4'h4,cand4}, checksum.
REQ-013 SHALL compute checksum as the bitwise XOR of the five preceding bytes, 8-bit, no carry.
REQ-014 SHALL send each byte as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-015 SHALL send bytes back-to-back: the next start bit follows the previous stop bit immediately, with no idle bits.
REQ-016 SHALL drive the start bit of byte 0 beginning the cycle after acceptance; busy SHALL rise in the same cycle.
REQ-017 SHALL use per-byte FSM states IDLE, START, DATA, STOP, plus a 3-bit byte index 0..5 and a 3-bit bit index 0..7.
REQ-018 SHALL advance from STOP to START while byte index < 5; after byte 5's stop bit SHALL go to IDLE.
REQ-019 SHALL assert done for exactly one cycle on the first IDLE cycle after the last stop bit, and SHALL deassert busy in that cycle.
REQ-020 SHALL take exactly 60*CLKS_PER_BIT cycles per frame from the start of byte 0 to the end of byte 5's stop bit.
REQ-021 SHALL accept a report_req present on the done cycle (busy=0) and start a new frame on the next cycle.
REQ-022 SHALL finish the current frame normally if mode falls mid-frame; mode gates acceptance only.
REQ-023 SHALL wrap the baud counter 0..CLKS_PER_BIT-1 and reload it at every bit boundary.

Reset
REQ-024 SHALL, while reset=0, force tx=1, busy=0 and done=0, set the FSM to IDLE, and clear the counters and snapshot registers.
REQ-025 SHALL abort any frame asserted mid-operation immediately, without a completion pulse; tx SHALL return high asynchronously.
REQ-026 SHALL ignore report_req on the first clock edge after reset deassertion is not required; acceptance is legal from that edge.

Structure
REQ-027 SHALL hold in a shared package vote_report_pkg: the header constant 0xA5, the frame length 6, the candidate ID nibbles, and the FSM state type.
REQ-028 SHALL place the single-byte 8N1 serializer (start/data/stop timing, baud counter) in sub-module uart_byte_tx; the top holds the snapshot, the byte sequencing and the checksum.
REQ-029 SHALL contain no combinational path from any input to tx.

Verification (CLKS_PER_BIT=4)
REQ-030 SHALL cover: tallies 3,0,9,15, req pulse in mode=1 -> tx bytes A5,13,20,39,4F,E0; done exactly 240 cycles after the start bit.
REQ-031 SHALL cover: all tallies 0 -> bytes A5,10,20,30,40,E5.
REQ-032 SHALL cover: req with mode=0 -> tx stays 1, busy stays 0, no done; req while busy -> ignored, frame unchanged, a single done.
REQ-033 SHALL cover: tallies change from 3 to 4 mid-frame -> transmitted cand1 byte stays 0x13.
REQ-034 SHALL cover: reset pulsed low during byte 2 -> tx=1 and busy=0 immediately, no done; a new req afterwards yields a full valid frame.
REQ-035 SHALL cover: req held high continuously -> back-to-back frames with a new start bit on the cycle after each done.
